// File: rtl/uart_pkg.sv
// Shared types and helpers for the memory-mapped UART receive path.
// Holds the receiver state encoding, bit-timing helpers and IO read-mux bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int UART_RX_DATA_BIT = 5;
  localparam int UART_RX_STAT_BIT = 6;

  function automatic int bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int half_cyc(input int clk_hz, input int baud);
    return bit_cyc(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with fall-through head; a pop frees a slot for a
// push in the same cycle, and a pop on an empty FIFO is ignored.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp[AW-1:0]] <= i_wdata;
        r_wp                <= r_wp + (AW+1)'(1);
      end
      if (w_do_pop) r_rp <= r_rp + (AW+1)'(1);
    end
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchronises RX, deserialises bytes into a FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky o_parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | half-bit wait, confirm start bit at its centre
// DATA   | sample 8 data bits LSB first at bit centres
// PARITY | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sample stop bit; push byte or flag framing error
// BREAK  | line held low after bad stop, wait for it to go high
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 115200,
  parameter int fifo_depth  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rx,
  input  logic       i_rd,
  input  logic       i_clr_err,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_full,
  output logic       o_frame_err,
  output logic       o_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int BIT_CYC  = bit_cyc(clk_freq_hz, baud_rate);
  localparam int HALF_CYC = half_cyc(clk_freq_hz, baud_rate);
  localparam int CNT_W    = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] BIT_LD  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_CYC - 1);

  logic             r_rx_meta;
  logic             r_rx_s;
  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_cnt_zero;
  logic             w_push;
  logic             w_frame_evt;
  logic             w_overrun_evt;
  logic             w_empty;
  logic             w_full;
  logic             r_frame_err;
  logic             r_overrun;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bad;
  logic             w_par_bad_nxt;
  logic             w_par_evt;
  logic             r_parity_err;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_par_evt     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_cnt_nxt   = HALF_LD;
          w_state_nxt = START;
`ifdef UART_RX_PARITY_EN
          w_par_bad_nxt = 1'b0;
`endif
        end
      end
      START: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!r_rx_s) begin
          w_cnt_nxt   = BIT_LD;
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_shift_nxt[r_idx] = r_rx_s;
          w_cnt_nxt          = BIT_LD;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_par_bad_nxt = (r_rx_s != ^r_shift);
          w_par_evt     = (r_rx_s != ^r_shift);
          w_cnt_nxt     = BIT_LD;
          w_state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_rx_s) begin
`ifdef UART_RX_PARITY_EN
          w_push = ~r_par_bad;
`else
          w_push = 1'b1;
`endif
          w_state_nxt = IDLE;
        end else begin
          w_frame_evt = 1'b1;
          w_state_nxt = BREAK;
        end
      end
      BREAK: begin
        if (r_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Full FIFO without a same-cycle pop drops the incoming byte.
  assign w_overrun_evt = w_push & w_full & ~i_rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_frame_evt)    r_frame_err <= 1'b1;
      else if (i_clr_err) r_frame_err <= 1'b0;
      if (w_overrun_evt)  r_overrun <= 1'b1;
      else if (i_clr_err) r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (w_par_evt)      r_parity_err <= 1'b1;
      else if (i_clr_err) r_parity_err <= 1'b0;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (fifo_depth),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (i_rd),
    .o_rdata (o_data),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign o_valid     = ~w_empty;
  assign o_full      = w_full;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`endif

endmodule
